ahb_apb_bridge: RTL and testbench



---
 rtl/ahb_apb_pkg.sv | 17 +
 rtl/apb_timeout_ctr.sv | 34 +++
 rtl/ahb_apb_bridge.sv | 144 ++++++++++++++
 tb/tb_ahb_apb_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } apb_state_t;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS cycles spent waiting on pready. The count saturates at
// TIMEOUT; expired flags the waiting cycle whose increment reaches TIMEOUT,
// so the FSM aborts after exactly TIMEOUT unanswered ACCESS cycles.
// TIMEOUT = 0 disables the abort entirely.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic hclk,
  input  logic hreset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  // Wait-cycle counter: cleared per transfer, saturating, never wraps
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT > 0) && enable && (cnt == CNT_LAST);

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB responder that turns one granted single transfer into one APB
// SETUP/ACCESS transfer, with grant handshake and pready timeout abort.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hreqb,
  output logic              hgrantb,
  input  logic [3:0]        hsel,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready_out,
  output logic              hresp,
  output logic [ADDR_W-1:0] paddr,
  output logic [1:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t state;
  logic       tmo_clear;
  logic       tmo_enable;
  logic       tmo_expired;
  logic       start;

  // hsel[1:0] belong to other slaves on the bus
  logic unused_hsel;
  assign unused_hsel = ^hsel[1:0];

  assign start      = hgrantb && hreqb && (htrans == HTRANS_NONSEQ) && (hsel[3:2] != 2'b00);
  assign tmo_clear  = (state == SETUP);
  assign tmo_enable = (state == ACCESS) && !pready;

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .hclk    (hclk),
    .hreset  (hreset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Transfer FSM; every output is set on the edge entering the state it belongs to
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= IDLE;
      hgrantb    <= 1'b0;
      hready_out <= 1'b0;
      hresp      <= HRESP_OKAY;
      hrdata     <= '0;
      psel       <= 2'b00;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          hready_out <= 1'b0;
          hresp      <= HRESP_OKAY;
          if (start) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            if (hsel[3:2] == 2'b11) begin
              // both peripherals selected: reject without touching APB
              hresp <= HRESP_ERROR;
              state <= ERR1;
            end else begin
              psel  <= hsel[3:2];
              state <= SETUP;
            end
          end else begin
            hgrantb <= hreqb;
          end
        end
        SETUP: begin
          // hwdata arrives in the AHB data phase, i.e. during SETUP
          pwdata  <= hwdata;
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel    <= 2'b00;
            penable <= 1'b0;
            if (pslverr) begin
              hresp <= HRESP_ERROR;
              state <= ERR1;
            end else begin
              hready_out <= 1'b1;
              if (!pwrite) begin
                hrdata <= prdata;
              end
              state <= RESP;
            end
          end else if (tmo_expired) begin
            psel    <= 2'b00;
            penable <= 1'b0;
            hresp   <= HRESP_ERROR;
            state   <= ERR1;
          end
        end
        RESP: begin
          hready_out <= 1'b0;
          hgrantb    <= 1'b0;
          state      <= IDLE;
        end
        ERR1: begin
          hready_out <= 1'b1;
          hresp      <= HRESP_ERROR;
          state      <= ERR2;
        end
        ERR2: begin
          hready_out <= 1'b0;
          hresp      <= HRESP_OKAY;
          hgrantb    <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          hready_out <= 1'b0;
          hresp      <= HRESP_OKAY;
          psel       <= 2'b00;
          penable    <= 1'b0;
          hgrantb    <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: AHB driver tasks, a behavioural APB peripheral
// and a response scoreboard fed by the driver and drained by a monitor.
module tb_ahb_apb_bridge;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              hclk;
  logic              hreset;
  logic              hreqb;
  logic              hgrantb;
  logic [3:0]        hsel;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready_out;
  logic              hresp;
  logic [ADDR_W-1:0] paddr;
  logic [1:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  ahb_apb_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hreqb      (hreqb),
    .hgrantb    (hgrantb),
    .hsel       (hsel),
    .htrans     (htrans),
    .haddr      (haddr),
    .hwrite     (hwrite),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready_out (hready_out),
    .hresp      (hresp),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // APB peripheral configuration
  int          cfg_wait  = 0;
  logic        cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = '0;
  int          apb_wait_cnt = 0;

  // monitor observations
  logic [1:0]  psel_seen    = 2'b00;
  int          pen_cycles   = 0;
  int          hresp_cycles = 0;
  int          resp_cnt     = 0;
  logic [15:0] paddr_seen   = '0;
  logic [31:0] pwdata_seen  = '0;
  logic        pwrite_seen  = 1'b0;
  logic        prev_err1    = 1'b0;

  logic [31:0] last_rd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic is_read, input logic [31:0] rd);
    exp_t e;
    if (!err && is_read) last_rd = rd;
    e.err   = err;
    e.rdata = last_rd;
    exp_q.push_back(e);
  endtask

  task automatic clear_obs();
    psel_seen    = 2'b00;
    pen_cycles   = 0;
    hresp_cycles = 0;
  endtask

  // Request, wait for grant, issue one NONSEQ and wait for completion.
  // lat counts falling edges from the start edge to the hready_out cycle.
  task automatic xfer(input logic [3:0] sel, input logic [15:0] addr, input logic wr,
                      input logic [31:0] wd, output int lat);
    int n;
    hreqb = 1'b1;
    n = 0;
    @(negedge hclk);
    while (!hgrantb && n < 20) begin
      @(negedge hclk);
      n++;
    end
    check("grant_wait", hgrantb, 1);
    htrans = 2'b10;
    hsel   = sel;
    haddr  = addr;
    hwrite = wr;
    @(negedge hclk);
    htrans = 2'b00;
    hsel   = 4'b0000;
    hreqb  = 1'b0;
    hwdata = wd;
    lat = 1;
    while (!hready_out && lat < 50) begin
      @(negedge hclk);
      lat++;
    end
    check("complete", hready_out, 1);
  endtask

  // Behavioural APB peripheral: answers after cfg_wait ACCESS cycles
  always @(negedge hclk) begin
    if (hreset) begin
      pready       = 1'b0;
      pslverr      = 1'b0;
      apb_wait_cnt = 0;
    end else if (psel != 2'b00 && penable) begin
      if (apb_wait_cnt >= cfg_wait) begin
        pready  = 1'b1;
        pslverr = cfg_err;
        prdata  = cfg_rdata;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
      end
      apb_wait_cnt++;
    end else begin
      pready       = 1'b0;
      pslverr      = 1'b0;
      apb_wait_cnt = 0;
    end
  end

  // Monitor: records APB activity and retires scoreboard entries on hready_out
  always @(negedge hclk) begin
    exp_t e;
    if (!hreset) begin
      if (psel != 2'b00) psel_seen = psel_seen | psel;
      if (penable) begin
        pen_cycles++;
        paddr_seen  = paddr;
        pwdata_seen = pwdata;
        pwrite_seen = pwrite;
      end
      if (hresp) hresp_cycles++;
      if (hready_out) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_resp", hready_out, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_hresp", hresp, e.err);
          check("resp_err1_before", prev_err1, e.err);
          if (!e.err) check("resp_hrdata", hrdata, e.rdata);
        end
      end
      prev_err1 = hresp && !hready_out;
    end else begin
      prev_err1 = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rc;
    int n;

    hreset  = 1'b1;
    hreqb   = 1'b0;
    hsel    = 4'b0000;
    htrans  = 2'b00;
    haddr   = '0;
    hwrite  = 1'b0;
    hwdata  = '0;
    prdata  = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    repeat (3) @(negedge hclk);

    check("rst_hgrantb", hgrantb, 0);
    check("rst_hready", hready_out, 0);
    check("rst_hresp", hresp, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    hreset = 1'b0;
    @(negedge hclk);

    // read, immediate pready
    clear_obs();
    cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'hCAFE0001;
    push_exp(1'b0, 1'b1, 32'hCAFE0001);
    xfer(4'b0100, 16'h0010, 1'b0, 32'h0, lat);
    check("rd_latency", lat, 3);
    @(negedge hclk);
    check("rd_hready_pulse", hready_out, 0);
    check("rd_grant_fall", hgrantb, 0);
    check("rd_psel", psel_seen, 2'b01);
    check("rd_paddr", paddr_seen, 16'h0010);
    check("rd_pwrite", pwrite_seen, 0);
    check("rd_pen_cycles", pen_cycles, 1);
    @(negedge hclk);

    // write, three wait states
    clear_obs();
    rc = resp_cnt;
    cfg_wait = 3; cfg_rdata = 32'hDEAD0000;
    push_exp(1'b0, 1'b0, 32'h0);
    xfer(4'b1000, 16'h0024, 1'b1, 32'h12345678, lat);
    repeat (2) @(negedge hclk);
    check("wr_psel", psel_seen, 2'b10);
    check("wr_pwdata", pwdata_seen, 32'h12345678);
    check("wr_pwrite", pwrite_seen, 1);
    check("wr_paddr", paddr_seen, 16'h0024);
    check("wr_pen_cycles", pen_cycles, 4);
    check("wr_single_pulse", resp_cnt, rc + 1);

    // slave error
    clear_obs();
    cfg_wait = 0; cfg_err = 1'b1;
    push_exp(1'b1, 1'b1, 32'h0);
    xfer(4'b0100, 16'h0030, 1'b0, 32'h0, lat);
    check("slverr_latency", lat, 4);
    @(negedge hclk);
    check("slverr_hresp_cycles", hresp_cycles, 2);
    check("slverr_hresp_clear", hresp, 0);
    cfg_err = 1'b0;
    @(negedge hclk);

    // pready stuck low: timeout after TIMEOUT ACCESS cycles
    clear_obs();
    cfg_wait = 1000;
    push_exp(1'b1, 1'b1, 32'h0);
    xfer(4'b1000, 16'h0044, 1'b0, 32'h0, lat);
    check("tmo_latency", lat, 7);
    check("tmo_psel_idle", psel, 0);
    @(negedge hclk);
    check("tmo_pen_cycles", pen_cycles, TIMEOUT);
    check("tmo_hresp_cycles", hresp_cycles, 2);
    cfg_wait = 0;
    @(negedge hclk);

    // both peripherals selected: error with no APB activity
    clear_obs();
    push_exp(1'b1, 1'b1, 32'h0);
    xfer(4'b1100, 16'h0050, 1'b0, 32'h0, lat);
    check("dual_latency", lat, 2);
    @(negedge hclk);
    check("dual_psel", psel_seen, 0);
    check("dual_pen", pen_cycles, 0);
    check("dual_hresp_cycles", hresp_cycles, 2);
    @(negedge hclk);

    // request pulse without a transfer
    clear_obs();
    hreqb = 1'b1;
    @(negedge hclk);
    hreqb = 1'b0;
    check("pulse_grant_hi", hgrantb, 1);
    @(negedge hclk);
    check("pulse_grant_lo", hgrantb, 0);
    @(negedge hclk);
    check("pulse_no_psel", psel_seen, 0);

    // reset during ACCESS
    clear_obs();
    cfg_wait = 1000;
    hreqb = 1'b1;
    n = 0;
    @(negedge hclk);
    while (!hgrantb && n < 20) begin
      @(negedge hclk);
      n++;
    end
    htrans = 2'b10; hsel = 4'b0100; haddr = 16'h0060; hwrite = 1'b0;
    @(negedge hclk);
    htrans = 2'b00; hsel = 4'b0000; hreqb = 1'b0;
    n = 0;
    while (!penable && n < 10) begin
      @(negedge hclk);
      n++;
    end
    check("rst_mid_access", penable, 1);
    rc = resp_cnt;
    #2 hreset = 1'b1;
    #1;
    check("rst_mid_psel", psel, 0);
    check("rst_mid_penable", penable, 0);
    check("rst_mid_hgrantb", hgrantb, 0);
    check("rst_mid_hready", hready_out, 0);
    last_rd = '0;
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    cfg_wait = 0;
    repeat (2) @(negedge hclk);
    check("rst_mid_no_resp", resp_cnt, rc);
    check("rst_mid_hrdata", hrdata, 0);

    clear_obs();
    cfg_rdata = 32'h5A5A1234;
    push_exp(1'b0, 1'b1, 32'h5A5A1234);
    xfer(4'b1000, 16'h0070, 1'b0, 32'h0, lat);
    check("post_rst_latency", lat, 3);
    @(negedge hclk);
    check("post_rst_psel", psel_seen, 2'b10);

    repeat (3) @(negedge hclk);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
